ifu: RTL and testbench
======================

Name: ifu

Overview:
- Instruction fetch unit: the producer side of the decode interface; drives pc/inst pairs into the decode stage.
- Issues word fetches to instruction memory over a valid/ready request channel, accepts responses, and buffers them in a small FIFO.
- Presents buffered pairs to decode with a valid/ready handshake and supports flush/redirect from branch/jump resolution.
- Sits between imem and decode in the single-cycle/early-pipeline core.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; power of 2, >=2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  XLEN  fetch address, word aligned.
- imem_rsp_valid_i  in  1  response valid; exactly one per accepted request, >=1 cycle later; no backpressure.
- imem_rsp_data_i  in  32  fetched instruction.
- redirect_valid_i  in  1  flush and restart fetch.
- redirect_pc_i  in  XLEN  new fetch pc.
- inst_valid_o  out  1  pc_o/inst_o valid to decode.
- inst_ready_i  in  1  decode consumes entry.
- pc_o  out  pc_t  pc of head entry.
- inst_o  out  inst_t  instruction of head entry.

Behaviour:
- Reset values: state=BOOT, fetch_pc=RESET_PC, buffer count=0; imem_req_valid_o=0, imem_req_addr_o=RESET_PC, inst_valid_o=0, pc_o=0, inst_o=0.
- At most one outstanding memory request.
- FSM states:
  - BOOT: -> REQ unconditionally on the first clock edge after reset deasserts, so no request is issued during reset.
  - REQ: imem_req_valid_o = (count < DEPTH); addr = fetch_pc. On handshake, req_pc_q <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^XLEN), -> WAIT.
  - WAIT: on imem_rsp_valid_i, push {req_pc_q, data} into the buffer, -> REQ.
  - DROP: on imem_rsp_valid_i, discard the response, -> REQ.
- Space rule: a request issues only when count<DEPTH, and count cannot grow while waiting, so a WAIT push never overflows.
- Redirect (highest priority, takes effect at the clock edge):
  - Buffer flushed (count=0, pointers reset).
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - REQ without handshake -> stays REQ.
  - REQ with handshake in the same cycle -> DROP, fetch_pc = redirect target.
  - WAIT without response -> DROP.
  - WAIT with response in the same cycle -> response discarded, -> REQ.
  - DROP -> stays DROP until its response arrives (the redirect target is kept).
- Decode side:
  - inst_valid_o = (count!=0); pc_o/inst_o come from the head register and are 0 when empty.
  - Pop on inst_valid_o & inst_ready_i & !redirect_valid_i.
  - Push and pop in the same cycle: count unchanged; legal when full.
  - Pointers wrap modulo DEPTH.
- Latency: a response arriving in cycle N is visible on inst_valid_o in cycle N+1. There is no combinational path from imem_rsp to the decode outputs.
- Best-case throughput: one instruction per 2 cycles (REQ/WAIT alternate).
- Reset asserted mid-operation: all state returns to reset values immediately. An in-flight response after reset release must not occur; memory is reset together with the unit.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_o (32) and perf_stall_o (32), both reset to 0 and wrapping.
  - perf_fetch_o counts decode handshakes.
  - perf_stall_o counts cycles with state=REQ, count==DEPTH, and no redirect.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- liang_pkg: XLEN, pc_t, inst_t (existing); add ifu_state_e {BOOT, REQ, WAIT, DROP}, fetch_entry_t {pc_t pc; inst_t inst}, and RESET_PC_DEFAULT.
- Sub-module inst_buffer: parameterized DEPTH circular FIFO of fetch_entry_t with push/pop/flush, count, and head outputs.
- ifu holds the FSM, fetch_pc, and redirect logic.

Test Plan:
- Boot: release reset, ready=1, response 1 cycle later with data 32'h00000013 -> first request addr 8000_0000 in the cycle after BOOT; inst_valid_o=1, pc_o=8000_0000, inst_o=0000_0013 one cycle after the response; next request addr 8000_0004.
- Backpressure: inst_ready_i=0 for 10 cycles -> exactly DEPTH (2) entries buffered (pc 8000_0000, 8000_0004); imem_req_valid_o=0 while full; on release, pops occur in order with no loss or duplication.
- Redirect in WAIT: redirect to 8000_0102 before the response -> response discarded (never on inst_o); next request addr 8000_0100; buffer empty the cycle after redirect.
- Simultaneous redirect and request handshake at 8000_0008 with target 8000_0200 -> state DROP; the next request after the dropped response uses 8000_0200.
- Simultaneous push and pop when full -> count stays 2, order preserved; wrap across 4+ pointer laps checked against a scoreboard.
- Async reset asserted in WAIT with a full buffer -> outputs return to reset values without a clock; BOOT then fetches at RESET_PC. With IFU_PERF_CNT_EN: fetch/stall counters match scoreboard counts.

Source files
------------

// File: rtl/liang_pkg.sv
// Shared core types for the fetch path.
//   XLEN             : architectural address width
//   pc_t / inst_t    : program counter and raw instruction word
//   ifu_state_e      : fetch unit sequencing states
//   fetch_entry_t    : one buffered {pc, inst} pair
//   RESET_PC_DEFAULT : default first fetch address after reset
package liang_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [31:0]     inst_t;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    DROP
  } ifu_state_e;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;

  localparam pc_t RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/inst_buffer.sv
// Circular FIFO of fetched {pc, inst} pairs.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : entry to store
//   pop_i         : advance the head
//   flush_i       : drop every entry and reset pointers (wins over push/pop)
//   count_o       : number of valid entries (0..DEPTH)
//   head_o        : entry at the head; meaningless when count_o == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module inst_buffer
  import liang_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: fetches words from imem (one request in flight),
// buffers {pc, inst} pairs and hands them to decode; branch/jump redirects
// flush the buffer and restart fetch.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   imem_req_*           : fetch request channel (valid/ready, word address)
//   imem_rsp_*           : fetch response, one per accepted request, no stall
//   redirect_valid_i/pc_i: flush and restart at redirect_pc_i (aligned down)
//   inst_valid_o/ready_i : decode handshake
//   pc_o, inst_o         : head entry, zero when empty
//   perf_fetch_o/stall_o : only with IFU_PERF_CNT_EN defined; decode
//                          handshakes and full-buffer REQ cycles
//
// state | meaning
// BOOT  | first cycle after reset, no request yet
// REQ   | request fetch_pc when the buffer has room
// WAIT  | request accepted, response goes into the buffer
// DROP  | request accepted before a redirect, response is discarded
module ifu
  import liang_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT,
  parameter int  DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output pc_t         imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_valid_i,
  input  pc_t         redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output pc_t         pc_o,
  output inst_t       inst_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e    state_q, state_d;
  pc_t           fetch_pc_q, fetch_pc_d;
  pc_t           req_pc_q, req_pc_d;
  logic          req_hs;
  logic          push, pop, full;
  logic [CW-1:0] count;
  fetch_entry_t  head;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign full             = (count == CW'(DEPTH));
  assign imem_req_valid_o = (state_q == REQ) && !full;
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (req_hs) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + pc_t'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          push    = 1'b1;
          state_d = REQ;
        end
      end
      DROP: if (imem_rsp_valid_i) state_d = REQ;
    endcase
    // Any request still owed a response after this edge belongs to the old
    // path, so it must be waited out in DROP instead of WAIT.
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i & ~pc_t'(3);
      push       = 1'b0;
      if (state_d == WAIT) state_d = DROP;
    end
  end

  assign pop = inst_valid_o && inst_ready_i && !redirect_valid_i;

  inst_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i ('{pc: req_pc_q, inst: imem_rsp_data_i}),
    .pop_i       (pop),
    .flush_i     (redirect_valid_i),
    .count_o     (count),
    .head_o      (head)
  );

  assign inst_valid_o = (count != '0);
  assign pc_o         = inst_valid_o ? head.pc   : '0;
  assign inst_o       = inst_valid_o ? head.inst : '0;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pop) perf_fetch_o <= perf_fetch_o + 32'd1;
      if ((state_q == REQ) && full && !redirect_valid_i)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  import liang_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready;
  pc_t         req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  pc_t         redirect_pc;
  logic        inst_valid, inst_ready;
  pc_t         pc;
  inst_t       inst;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          budget_lim;
  int          hs_count;
  int          rsp_delay;
  int          pop_cnt;
  logic [63:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  // Memory grants requests only while the bench has issued budget for them.
  assign req_ready = (hs_count < budget_lim);

  ifu dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .pc_o             (pc),
    .inst_o           (inst)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_o     (perf_fetch),
    .perf_stall_o     (perf_stall)
`endif
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] d);
    exp_q.push_back({p, d});
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0 && budget_lim == hs_count && !inst_valid) done = 1'b1;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic wait_hs(input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (req_valid && req_ready) found = 1'b1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp_addr);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (req_valid) found = 1'b1;
    end
    chk({nm, "_seen"}, 32'(found), 32'd1);
    chk({nm, "_addr"}, req_addr, exp_addr);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_valid"},  32'(req_valid),  32'd0);
    chk({nm, "_req_addr"},   req_addr,        32'h8000_0000);
    chk({nm, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({nm, "_pc"},         pc,              32'h0);
    chk({nm, "_inst"},       inst,            32'h0);
  endtask

  // Instruction memory: one response per accepted request, rsp_delay cycles later.
  initial begin
    bit          hs;
    logic [31:0] hs_addr;
    bit          pend;
    logic [31:0] paddr;
    int          wcnt;
    hs = 1'b0; pend = 1'b0; hs_addr = '0; paddr = '0; wcnt = 0;
    hs_count  = 0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && req_valid && req_ready) begin
        hs      = 1'b1;
        hs_addr = req_addr;
      end
      @(posedge clk_i);
      #1;
      rsp_valid = 1'b0;
      if (!rst_ni) begin
        hs   = 1'b0;
        pend = 1'b0;
      end else begin
        if (hs) begin
          hs_count++;
          pend  = 1'b1;
          paddr = hs_addr;
          wcnt  = rsp_delay - 1;
          hs    = 1'b0;
        end
        if (pend) begin
          if (wcnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_data(paddr);
            pend      = 1'b0;
          end else begin
            wcnt--;
          end
        end
      end
    end
  end

  // Monitor: every decode handshake pops the scoreboard.
  initial begin
    logic [63:0] e;
    pop_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pop_cnt = 0;
      end else if (inst_valid && inst_ready && !redirect_valid) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got pc %h inst %h, expected no entry", pc, inst);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc",   pc,   e[63:32]);
          chk("pop_inst", inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    pat            = 16'b1011_0010_1110_0100;
    rst_ni         = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    budget_lim     = 0;
    rsp_delay      = 1;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("rst");

    // Boot: first request right after BOOT, data visible one cycle after response.
    push_exp(32'h8000_0000, 32'h0000_0013);
    push_exp(32'h8000_0004, 32'h0004_0013);
    push_exp(32'h8000_0008, 32'h0008_0013);
    budget_lim = hs_count + 3;
    inst_ready = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("boot_req_valid", 32'(req_valid), 32'd1);
    chk("boot_req_addr",  req_addr,       32'h8000_0000);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk_i);
        if (rsp_valid) seen = 1'b1;
      end
      chk("boot_rsp_seen", 32'(seen), 32'd1);
    end
    @(negedge clk_i);
    chk("boot_inst_valid", 32'(inst_valid), 32'd1);
    chk("boot_pc",         pc,              32'h8000_0000);
    chk("boot_inst",       inst,            32'h0000_0013);
    chk("boot_next_addr",  req_addr,        32'h8000_0004);
    wait_drain(50, "boot_drain");

    // Backpressure: buffer fills to DEPTH then requests stop.
    tick();
    inst_ready = 1'b0;
    push_exp(32'h8000_000C, 32'h000C_0013);
    push_exp(32'h8000_0010, 32'h0010_0013);
    push_exp(32'h8000_0014, 32'h0014_0013);
    push_exp(32'h8000_0018, 32'h0018_0013);
    budget_lim = hs_count + 4;
    repeat (10) tick();
    @(negedge clk_i);
    chk("bp_req_valid",  32'(req_valid),             32'd0);
    chk("bp_inst_valid", 32'(inst_valid),            32'd1);
    chk("bp_head_pc",    pc,                         32'h8000_000C);
    chk("bp_head_inst",  inst,                       32'h000C_0013);
    chk("bp_fetched",    32'(budget_lim - hs_count), 32'd2);
    tick();
    inst_ready = 1'b1;
    wait_drain(60, "bp_drain");

    // Irregular decode readiness across several pointer laps.
    tick();
    for (int i = 0; i < 12; i++)
      push_exp(32'h8000_001C + 32'(4 * i), mem_data(32'h8000_001C + 32'(4 * i)));
    budget_lim = hs_count + 12;
    for (int c = 0; c < 80; c++) begin
      tick();
      inst_ready = pat[c % 16];
    end
    tick();
    inst_ready = 1'b1;
    wait_drain(100, "wrap_drain");

    // Redirect while waiting: buffered entry flushed, response dropped.
    tick();
    inst_ready = 1'b0;
    budget_lim = hs_count + 1;
    repeat (6) tick();
    @(negedge clk_i);
    chk("rw_prefill", 32'(inst_valid), 32'd1);
    tick();
    rsp_delay  = 3;
    budget_lim = hs_count + 1;
    wait_hs("rw_hs");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    rsp_delay      = 1;
    @(negedge clk_i);
    chk("rw_flushed",   32'(inst_valid), 32'd0);
    chk("rw_no_req",    32'(req_valid),  32'd0);
    repeat (5) tick();
    push_exp(32'h8000_0100, 32'h0100_0013);
    budget_lim = hs_count + 1;
    wait_req("rw_next", 32'h8000_0100);
    tick();
    inst_ready = 1'b1;
    wait_drain(50, "rw_drain");

    // Redirect in the same cycle as a request handshake.
    tick();
    budget_lim     = hs_count + 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk_i);
    chk("rh_hs_valid", 32'(req_valid), 32'd1);
    chk("rh_hs_addr",  req_addr,       32'h8000_0104);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk_i);
    chk("rh_drop_no_req", 32'(req_valid), 32'd0);
    repeat (3) tick();
    push_exp(32'h8000_0200, 32'h0200_0013);
    budget_lim = hs_count + 1;
    wait_req("rh_next", 32'h8000_0200);
    wait_drain(50, "rh_drain");

    // Asynchronous reset while waiting with a buffered entry.
    tick();
    inst_ready = 1'b0;
    budget_lim = hs_count + 1;
    repeat (6) tick();
    rsp_delay  = 3;
    budget_lim = hs_count + 1;
    wait_hs("ar_hs");
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("ar");
    repeat (2) tick();
    rsp_delay = 1;
    push_exp(32'h8000_0000, 32'h0000_0013);
    budget_lim = hs_count + 1;
    inst_ready = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ar_boot_req_valid", 32'(req_valid), 32'd1);
    chk("ar_boot_req_addr",  req_addr,       32'h8000_0000);
    wait_drain(50, "ar_drain");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch", perf_fetch, 32'(pop_cnt));
    $display("perf_stall count %0d", perf_stall);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
